// File: rtl/mips_run_pkg.sv
// Shared types and default constants for the top_MIPS run controller.
package mips_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_e;

    localparam int          DEF_RESET_CYCLES = 2;
    localparam int          DEF_MAX_CYCLES   = 90;
    localparam int          DEF_STALL_CYCLES = 4;
    localparam logic [31:0] DEF_HALT_PC      = 32'h0000_003C;

endpackage

// File: rtl/mips_pc_stall_det.sv
// Self-loop detector: flags when the PC has been sampled unchanged for
// STALL_CYCLES consecutive enabled samples.
module mips_pc_stall_det #(
    parameter int PC_WIDTH     = 32,
    parameter int STALL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic                o_stalled
);
    localparam int              SW      = $clog2(STALL_CYCLES) + 1;
    localparam logic [SW-1:0]   CNT_MAX = SW'(STALL_CYCLES - 1);

    logic [PC_WIDTH-1:0] r_prev_pc;
    logic                r_prev_vld;
    logic [SW-1:0]       r_cnt;
    logic                w_same;
    logic [SW-1:0]       w_cnt_next;

    // The first sample after a clear only loads the reference; it has no predecessor.
    assign w_same = r_prev_vld && (i_pc == r_prev_pc);

    always_comb begin
        w_cnt_next = '0;
        if (w_same) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    assign o_stalled = i_en && w_same && (w_cnt_next == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_pc  <= '0;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
        end else if (i_clr) begin
            r_prev_pc  <= '0;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
        end else if (i_en) begin
            r_prev_vld <= 1'b1;
            r_cnt      <= w_cnt_next;
            if (!w_same) begin
                r_prev_pc <= i_pc;
            end
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for top_MIPS: holds the core in reset, runs it, and stops it
// on a halt PC, a self-looping PC, or a watchdog timeout.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  CNT_WIDTH    = 16,
    parameter int                  RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int                  MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int                  STALL_CYCLES = DEF_STALL_CYCLES,
    parameter logic [PC_WIDTH-1:0] HALT_PC      = PC_WIDTH'(DEF_HALT_PC),
    parameter bit                  HALT_PC_EN   = 1'b1,
    parameter bit                  AUTO_START   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc_in,
    output logic                 core_reset,
    output logic                 core_run,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [PC_WIDTH-1:0]  final_pc,
    output logic [2:0]           o_dbg_state
);
    localparam int                   HOLD_W    = $clog2(RESET_CYCLES) + 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    run_state_e           r_state, w_state_next;
    logic [HOLD_W-1:0]    r_hold_cnt, w_hold_next;
    logic [CNT_WIDTH-1:0] r_cycle_count, w_count_next;
    logic [PC_WIDTH-1:0]  r_final_pc, w_final_pc_next;
    logic                 r_done, w_done_next;
    logic                 r_timeout, w_timeout_next;
    logic                 r_core_reset, r_core_run, r_busy;
    logic                 w_in_run, w_stalled, w_halt, w_last_cycle;

    assign w_in_run = (r_state == ST_RUN);

    mips_pc_stall_det #(
        .PC_WIDTH     (PC_WIDTH),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall_det (
        .clk       (clk),
        .rst_n     (reset),
        .i_clr     (!w_in_run),
        .i_en      (w_in_run),
        .i_pc      (pc_in),
        .o_stalled (w_stalled)
    );

    assign w_halt       = (HALT_PC_EN && (pc_in == HALT_PC)) || w_stalled;
    assign w_last_cycle = (r_cycle_count == CNT_LAST);

    always_comb begin
        w_state_next    = r_state;
        w_hold_next     = r_hold_cnt;
        w_count_next    = r_cycle_count;
        w_done_next     = r_done;
        w_timeout_next  = r_timeout;
        w_final_pc_next = r_final_pc;
        case (r_state)
            ST_IDLE: begin
                if (start || AUTO_START) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) w_state_next = ST_RUN;
                else                         w_hold_next  = r_hold_cnt + 1'b1;
            end
            ST_RUN: begin
                // Halt takes priority over a timeout landing on the same cycle.
                w_count_next = r_cycle_count + 1'b1;
                if (w_halt) begin
                    w_state_next    = ST_DONE;
                    w_done_next     = 1'b1;
                    w_final_pc_next = pc_in;
                end else if (w_last_cycle) begin
                    w_state_next    = ST_TIMEOUT;
                    w_timeout_next  = 1'b1;
                    w_final_pc_next = pc_in;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (start) w_state_next = ST_HOLD;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if ((w_state_next == ST_HOLD) && (r_state != ST_HOLD)) begin
            w_hold_next     = '0;
            w_count_next    = '0;
            w_done_next     = 1'b0;
            w_timeout_next  = 1'b0;
            w_final_pc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_final_pc    <= '0;
            r_core_reset  <= 1'b1;
            r_core_run    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold_cnt    <= w_hold_next;
            r_cycle_count <= w_count_next;
            r_done        <= w_done_next;
            r_timeout     <= w_timeout_next;
            r_final_pc    <= w_final_pc_next;
            r_core_reset  <= (w_state_next == ST_IDLE) || (w_state_next == ST_HOLD);
            r_core_run    <= (w_state_next == ST_RUN);
            r_busy        <= (w_state_next == ST_HOLD) || (w_state_next == ST_RUN);
        end
    end

    assign core_reset  = r_core_reset;
    assign core_run    = r_core_run;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign final_pc    = r_final_pc;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: three configurations (defaults, halt-PC disabled,
// short timeout with manual start) checked against a program-level model.
module tb_mips_run_ctrl;
    import mips_run_pkg::*;

    logic        clk;
    logic [2:0]  rst_n;
    logic [2:0]  start;
    logic [31:0] pc [3];
    wire  [2:0]  core_reset, core_run, busy, done, timeout;
    wire  [15:0] cc  [3];
    wire  [31:0] fpc [3];
    wire  [2:0]  st  [3];

    logic [49:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // DUT 0: all defaults
    mips_run_ctrl u_dut_a (
        .clk(clk), .reset(rst_n[0]), .start(start[0]), .pc_in(pc[0]),
        .core_reset(core_reset[0]), .core_run(core_run[0]), .busy(busy[0]),
        .done(done[0]), .timeout(timeout[0]), .cycle_count(cc[0]),
        .final_pc(fpc[0]), .o_dbg_state(st[0])
    );

    // DUT 1: halt-PC compare disabled, only self-loop detection
    mips_run_ctrl #(.HALT_PC_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(rst_n[1]), .start(start[1]), .pc_in(pc[1]),
        .core_reset(core_reset[1]), .core_run(core_run[1]), .busy(busy[1]),
        .done(done[1]), .timeout(timeout[1]), .cycle_count(cc[1]),
        .final_pc(fpc[1]), .o_dbg_state(st[1])
    );

    // DUT 2: short watchdog, waits for start
    mips_run_ctrl #(.MAX_CYCLES(16), .AUTO_START(1'b0)) u_dut_c (
        .clk(clk), .reset(rst_n[2]), .start(start[2]), .pc_in(pc[2]),
        .core_reset(core_reset[2]), .core_run(core_run[2]), .busy(busy[2]),
        .done(done[2]), .timeout(timeout[2]), .cycle_count(cc[2]),
        .final_pc(fpc[2]), .o_dbg_state(st[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc_at(input logic [31:0] pc0, input logic [31:0] lim, input int n);
        logic [31:0] p;
        p = pc0 + 32'(4 * (n - 1));
        return (p > lim) ? lim : p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic wait_run(input int d);
        bit seen;
        seen = core_run[d];
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = core_run[d];
        end
        check("wait_run", seen, 1);
    endtask

    // Program: RUN cycle n presents pc0 + 4*(n-1), clamped at lim.
    task automatic run_prog(input int d, input logic [31:0] pc0, input logic [31:0] lim);
        int          halt_en, max_c, n;
        bit          fin, ended;
        logic        e_done, e_tmo;
        logic [15:0] e_cc;
        logic [31:0] e_pc, p;
        logic [49:0] got;
        halt_en = (d == 1) ? 0 : 1;
        max_c   = (d == 2) ? 16 : 90;
        fin = 0; e_done = 0; e_tmo = 0; e_cc = '0; e_pc = '0;
        for (int k = 1; k <= 1000 && !fin; k++) begin
            p = pc_at(pc0, lim, k);
            if (halt_en == 1 && p == 32'h3C) begin
                e_done = 1'b1; fin = 1;
            end else if (k >= 4 && pc_at(pc0, lim, k - 3) == p) begin
                e_done = 1'b1; fin = 1;
            end else if (k == max_c) begin
                e_tmo = 1'b1; fin = 1;
            end
            if (fin) begin
                e_cc = 16'(k);
                e_pc = p;
            end
        end
        exp_q.push_back({e_done, e_tmo, e_cc, e_pc});

        wait_run(d);
        n = 1;
        pc[d] = pc_at(pc0, lim, n);
        ended = 0;
        for (int c = 0; c < 300 && !ended; c++) begin
            tick();
            if (done[d] || timeout[d]) ended = 1;
            else begin
                n++;
                pc[d] = pc_at(pc0, lim, n);
            end
        end
        check("run_ends", ended, 1);
        got = exp_q.pop_front();
        check("done",        done[d],    got[49]);
        check("timeout",     timeout[d], got[48]);
        check("cycle_count", cc[d],      got[47:32]);
        check("final_pc",    fpc[d],     got[31:0]);
        check("end_run",     core_run[d],   0);
        check("end_busy",    busy[d],       0);
        check("end_reset",   core_reset[d], 0);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_state"},   st[d],         ST_IDLE);
        check({tag, "_corerst"}, core_reset[d], 1);
        check({tag, "_run"},     core_run[d],   0);
        check({tag, "_busy"},    busy[d],       0);
        check({tag, "_done"},    done[d],       0);
        check({tag, "_tmo"},     timeout[d],    0);
        check({tag, "_cc"},      cc[d],         0);
        check({tag, "_fpc"},     fpc[d],        0);
    endtask

    task automatic check_cleared(input int d, input string tag);
        check({tag, "_state"}, st[d],      ST_HOLD);
        check({tag, "_cc"},    cc[d],      0);
        check({tag, "_done"},  done[d],    0);
        check({tag, "_tmo"},   timeout[d], 0);
        check({tag, "_fpc"},   fpc[d],     0);
    endtask

    initial begin
        logic [31:0] r0;
        rst_n = 3'b000;
        start = 3'b000;
        for (int i = 0; i < 3; i++) pc[i] = '0;
        repeat (2) tick();
        check_idle(0, "rst_a");

        // Auto start: two HOLD cycles, then RUN
        rst_n[0] = 1'b1;
        tick();
        check("as_hold1_state", st[0], ST_HOLD);
        check("as_hold1_rst",   core_reset[0], 1);
        check("as_hold1_busy",  busy[0], 1);
        check("as_hold1_run",   core_run[0], 0);
        tick();
        check("as_hold2_rst",   core_reset[0], 1);
        tick();
        check("as_run_rst",     core_reset[0], 0);
        check("as_run_run",     core_run[0], 1);
        check("as_run_busy",    busy[0], 1);

        run_prog(0, 32'h0, 32'hFFFF_FFFF);            // halt PC at cycle 16
        pulse_start(0);
        check_cleared(0, "rs_a");
        run_prog(0, 32'h100, 32'hFFFF_FFFF);          // watchdog timeout
        pulse_start(0);
        r0 = 32'(4 * $urandom_range(64, 128));
        run_prog(0, r0, r0 + 32'(4 * $urandom_range(2, 20)));

        // Self-loop detection with halt PC disabled
        rst_n[1] = 1'b1;
        run_prog(1, 32'h0, 32'h20);
        pulse_start(1);
        run_prog(1, 32'h30, 32'h50);                  // passes 0x3C without halting

        // Manual start, ignored start in RUN, async abort
        rst_n[2] = 1'b1;
        repeat (4) tick();
        check_idle(2, "nostart_c");
        pulse_start(2);
        check("ms_hold_state", st[2], ST_HOLD);
        check("ms_hold_rst",   core_reset[2], 1);
        tick();
        check("ms_hold2_state", st[2], ST_HOLD);
        tick();
        check("ms_run_state", st[2], ST_RUN);
        check("ms_run_rst",   core_reset[2], 0);
        pc[2] = 32'h400;
        pulse_start(2);
        check("ign_start_state", st[2], ST_RUN);
        check("ign_start_cc",    cc[2], 1);
        pc[2] = 32'h404;
        #3;
        rst_n[2] = 1'b0;
        #1;
        check_idle(2, "abort_c");
        tick();
        rst_n[2] = 1'b1;
        repeat (3) tick();
        check("post_abort_state", st[2], ST_IDLE);
        pulse_start(2);
        run_prog(2, 32'h0, 32'hFFFF_FFFF);            // halt and timeout tie
        pulse_start(2);
        check_cleared(2, "rs_c");
        r0 = 32'(4 * $urandom_range(64, 128));
        run_prog(2, r0, r0 + 32'(4 * $urandom_range(2, 20)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle core top_MIPS.
- Holds the core in reset for a programmable number of cycles, then enables it.
- Counts execution cycles and detects program completion: a halt PC, or a PC stalled in a self-loop. It also detects a watchdog timeout.
- Replaces fixed-delay reset/finish sequencing; usable on silicon/FPGA and in simulation benches.

Parameters:
- PC_WIDTH, 32, width of observed program counter.
- CNT_WIDTH, 16, width of cycle counter and timeout compare.
- RESET_CYCLES, 2, cycles core_reset is held high after start (min 1).
- MAX_CYCLES, 90, RUN cycles before timeout (1..2^CNT_WIDTH-1).
- STALL_CYCLES, 4, consecutive cycles with unchanged pc_in that mean halted (min 2).
- HALT_PC, 32'h0000_003C, PC value that means halted.
- HALT_PC_EN, 1, enable HALT_PC compare.
- AUTO_START, 1, 1 = start automatically after reset release; 0 = wait for start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low controller reset.
- start  in  1  one-cycle start/restart request.
- pc_in  in  PC_WIDTH  core program counter.
- core_reset  out  1  active-high reset to top_MIPS.
- core_run  out  1  core clock-enable; high only in RUN.
- busy  out  1  high in HOLD or RUN.
- done  out  1  sticky; halt detected.
- timeout  out  1  sticky; MAX_CYCLES reached without halt.
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed.
- final_pc  out  PC_WIDTH  pc_in captured at halt or timeout.

Behaviour:
- Reset low (asynchronous):
  - state=IDLE, core_reset=1, core_run=0, busy=0, done=0, timeout=0, cycle_count=0, final_pc=0.
  - Hold counter and stall counter cleared.
- States: IDLE, HOLD, RUN, DONE, TIMEOUT. All outputs are registered.
- IDLE:
  - core_reset=1.
  - Moves to HOLD on start, or on the first clock after reset release when AUTO_START=1.
- HOLD:
  - core_reset=1, busy=1, hold counter increments each cycle.
  - After exactly RESET_CYCLES cycles in HOLD, moves to RUN.
  - Entering HOLD clears cycle_count, done, timeout, final_pc and the stall counter.
- RUN:
  - core_reset=0, core_run=1, busy=1.
  - cycle_count increments by 1 each RUN cycle; it never wraps.
  - Halt condition is either:
    - HALT_PC_EN and pc_in==HALT_PC; or
    - the stall counter reaches STALL_CYCLES-1, i.e. pc_in is equal to the previous-cycle pc_in for STALL_CYCLES consecutive samples.
  - Timeout condition: cycle_count==MAX_CYCLES-1 in the current cycle, i.e. the MAX_CYCLES-th RUN cycle.
  - Halt and timeout in the same cycle: halt wins; go to DONE, timeout stays 0.
  - On exit: final_pc<=pc_in and cycle_count takes its final increment.
  - The stall reference PC is reloaded on every PC change.
- DONE / TIMEOUT:
  - core_reset=0, core_run=0 (core frozen, state preserved for inspection), busy=0.
  - done=1 in DONE; timeout=1 in TIMEOUT.
  - start moves to HOLD (restart).
- Latency: start sampled high at edge t gives HOLD at t+1, core_reset falling at t+1+RESET_CYCLES, and core_run rising at the same edge.
- start is ignored in HOLD and RUN.
- Reset asserted mid-HOLD or mid-RUN aborts immediately to IDLE values; no partial results are kept.
- pc_in is sampled only in RUN; its value in other states has no effect.

Decomposition:
- Package mips_run_pkg:
  - State encoding typedef (5 states).
  - Default constants for RESET_CYCLES, MAX_CYCLES, STALL_CYCLES, HALT_PC.
- Sub-module mips_pc_stall_det:
  - Ports: previous-PC register, equality compare, saturating stall counter, clear and enable inputs, stalled output.
  - Instantiated once.

Test Plan (defaults unless stated):
- Auto start: reset low 2 cycles then high → core_reset high for HOLD cycles 1–2, low with core_run=1 on the 3rd edge after release; busy=1.
- Halt PC: drive pc_in 0,4,8,…,0x3C, one step per cycle → done=1, final_pc=0x3C, cycle_count=16, core_run=0, timeout=0.
- Stall halt (HALT_PC_EN=0): pc_in steps to 0x20 then holds → done asserted on the 4th consecutive 0x20 sample, final_pc=0x20.
- Timeout: pc_in increments forever, never 0x3C → timeout=1 after 90 RUN cycles, cycle_count=90, done=0.
- Tie: MAX_CYCLES=16 with pc reaching 0x3C on RUN cycle 16 → done=1, timeout=0.
- Restart and async abort (AUTO_START=0):
  - No start → stays IDLE.
  - start pulse → HOLD; a second start in RUN is ignored.
  - After DONE, start → counters cleared, HOLD again.
  - reset low mid-RUN → core_reset=1 and cycle_count=0 immediately, without waiting for a clock edge.
